// File: rtl/arc4_pkg.sv
// arc4_pkg: shared types and constants for the ARC4 key-scheduling stage
//   ksa_state_t : key-scheduling FSM states
//   KEY_BYTES   : key length in bytes
//   S_LAST      : last S-box index processed
package arc4_pkg;
    localparam int KEY_BYTES = 3;
    localparam logic [7:0] S_LAST = 8'hFF;
    typedef enum logic [2:0] {IDLE, RD_I, WAIT_I, RD_J, WAIT_J, WR_I, WR_J, DONE} ksa_state_t;
endpackage

// File: rtl/arc4_keybyte.sv
// arc4_keybyte: selects key byte (i mod 3) from the latched 24-bit key
//   key [23:0] in  : latched key, byte 0 in key[23:16]
//   sel [1:0]  in  : i mod 3
//   kb  [7:0]  out : selected key byte
module arc4_keybyte (
    input  logic [23:0] key,
    input  logic [1:0]  sel,
    output logic [7:0]  kb
);
    always_comb kb = sel == 2'd0 ? key[23:16] : sel == 2'd1 ? key[15:8] : key[7:0];
endmodule

// File: rtl/ksa.sv
// ksa: ARC4 key scheduling, permutes the shared 256x8 S memory in place
//   clk, rst        : clock, synchronous active-high reset
//   en / rdy        : start request / idle indicator
//   key [23:0]      : key, latched on accept
//   s_addr [7:0]    : S memory address
//   s_rddata [7:0]  : S read data, one cycle after s_addr
//   s_wrdata [7:0]  : S write data
//   s_wren          : S write enable
module ksa
    import arc4_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    output logic        rdy,
    input  logic [23:0] key,
    output logic [7:0]  s_addr,
    input  logic [7:0]  s_rddata,
    output logic [7:0]  s_wrdata,
    output logic        s_wren
);
    ksa_state_t state;
    logic [7:0] i, j, si, sj, kb;
    logic [23:0] key_q;
    // i mod KEY_BYTES, stepped alongside i to avoid a divider
    logic [1:0] m;

    arc4_keybyte u_keybyte (.key(key_q), .sel(m), .kb(kb));

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            i     <= '0;
            j     <= '0;
            si    <= '0;
            sj    <= '0;
            key_q <= '0;
            m     <= '0;
        end else begin
            case (state)
                IDLE: if (en) begin
                    key_q <= key;
                    i     <= '0;
                    j     <= '0;
                    m     <= '0;
                    state <= RD_I;
                end
                RD_I: state <= WAIT_I;
                WAIT_I: begin
                    si    <= s_rddata;
                    j     <= j + s_rddata + kb;
                    state <= RD_J;
                end
                RD_J: state <= WAIT_J;
                WAIT_J: begin
                    sj    <= s_rddata;
                    state <= WR_I;
                end
                WR_I: state <= WR_J;
                WR_J: if (i == S_LAST) state <= DONE;
                else begin
                    i     <= i + 8'd1;
                    m     <= m == 2'(KEY_BYTES - 1) ? 2'd0 : m + 2'd1;
                    state <= RD_I;
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        rdy      = state == IDLE;
        s_wren   = state == WR_I || state == WR_J;
        s_addr   = (state == RD_I || state == WAIT_I || state == WR_I) ? i :
                   (state == RD_J || state == WAIT_J || state == WR_J) ? j : 8'd0;
        s_wrdata = state == WR_I ? sj : state == WR_J ? si : 8'd0;
    end
endmodule

// File: tb/tb_ksa.sv
// tb_ksa: self-checking bench for ksa against a software ARC4 key-schedule model
module tb_ksa;
    logic        clk = 1'b0, rst = 1'b1, en = 1'b0, init = 1'b0;
    logic [23:0] key = '0;
    logic [7:0]  s_addr, s_rddata, s_wrdata;
    logic        s_wren, rdy;
    logic [7:0]  mem [256];
    logic [7:0]  ref_s [256];
    logic [7:0]  exp_a [512], exp_d [512], act_a [512], act_d [512];
    int tests = 0, failed = 0;

    always #5 clk = ~clk;

    ksa dut (.clk(clk), .rst(rst), .en(en), .rdy(rdy), .key(key), .s_addr(s_addr),
             .s_rddata(s_rddata), .s_wrdata(s_wrdata), .s_wren(s_wren));

    always @(posedge clk) begin
        if (init) for (int k = 0; k < 256; k++) mem[k] <= 8'(k);
        else if (s_wren) mem[s_addr] <= s_wrdata;
        s_rddata <= mem[s_addr];
    end

    task automatic model(input logic [23:0] k);
        logic [7:0] s [256];
        logic [7:0] kb [3];
        logic [7:0] j, t;
        kb[0] = k[23:16]; kb[1] = k[15:8]; kb[2] = k[7:0];
        for (int n = 0; n < 256; n++) s[n] = 8'(n);
        j = 0;
        for (int n = 0; n < 256; n++) begin
            j = j + s[n] + kb[n % 3];
            exp_a[2*n] = 8'(n); exp_d[2*n] = s[j];
            exp_a[2*n+1] = j;   exp_d[2*n+1] = s[n];
            t = s[n]; s[n] = s[j]; s[j] = t;
        end
        for (int n = 0; n < 256; n++) ref_s[n] = s[n];
    endtask

    task automatic init_s();
        @(negedge clk) init = 1'b1;
        @(negedge clk) init = 1'b0;
    endtask

    function automatic int s_diff();
        int d = 0;
        for (int n = 0; n < 256; n++) if (mem[n] !== ref_s[n]) d++;
        return d;
    endfunction

    function automatic int w_diff();
        int d = 0;
        for (int n = 0; n < 512; n++) if (act_a[n] !== exp_a[n] || act_d[n] !== exp_d[n]) d++;
        return d;
    endfunction

    // Starts a run, optionally pulses en at cycle pulse_at, and records writes until rdy returns.
    task automatic run(input logic [23:0] k, input int pulse_at,
                       output int lat, output int nw, output int wren_bad);
        @(negedge clk); key = k; en = 1'b1;
        @(negedge clk); en = 1'b0; key = 24'($urandom);
        lat = -1; nw = 0; wren_bad = 0;
        for (int c = 0; c < 2000; c++) begin
            if (rdy) begin lat = c; break; end
            if (s_wren !== (c < 1536 && c % 6 >= 4)) wren_bad++;
            if (s_wren) begin
                if (nw < 512) begin act_a[nw] = s_addr; act_d[nw] = s_wrdata; end
                nw++;
            end
            en = (c == pulse_at);
            @(negedge clk);
        end
        en = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            tests++;
            if (rdy !== 1'b1 || s_wren !== 1'b0) begin
                failed++;
                $display("FAIL reset_idle cycle %0d: rdy=%b s_wren=%b, required rdy=1 s_wren=0", c, rdy, s_wren);
            end
        end
    endtask

    task automatic test_first_iter();
        int lat, nw, wb;
        init_s(); model(24'h010203);
        run(24'h010203, -1, lat, nw, wb);
        tests++; if (act_a[0] !== 8'd0) begin failed++; $display("FAIL first_wr_addr0: got %0d required 0", act_a[0]); end
        tests++; if (act_d[0] !== 8'd1) begin failed++; $display("FAIL first_wr_data0: got %0d required 1", act_d[0]); end
        tests++; if (act_a[1] !== 8'd1) begin failed++; $display("FAIL first_wr_addr1: got %0d required 1", act_a[1]); end
        tests++; if (act_d[1] !== 8'd0) begin failed++; $display("FAIL first_wr_data1: got %0d required 0", act_d[1]); end
        tests++; if (s_diff() != 0) begin failed++; $display("FAIL key010203_final_s: %0d bytes differ, required 0", s_diff()); end
    endtask

    task automatic test_zero_key();
        int lat, nw, wb;
        init_s(); model(24'h000000);
        run(24'h000000, -1, lat, nw, wb);
        tests++; if (lat != 1537) begin failed++; $display("FAIL zero_latency: got %0d required 1537", lat); end
        tests++; if (nw != 512) begin failed++; $display("FAIL zero_wren_count: got %0d required 512", nw); end
        tests++; if (wb != 0) begin failed++; $display("FAIL zero_wren_timing: %0d bad cycles, required 0", wb); end
        tests++; if (w_diff() != 0) begin failed++; $display("FAIL zero_write_seq: %0d writes differ, required 0", w_diff()); end
        tests++; if (s_diff() != 0) begin failed++; $display("FAIL zero_final_s: %0d bytes differ, required 0", s_diff()); end
    endtask

    task automatic test_random_keys();
        int lat, nw, wb;
        logic [23:0] k;
        for (int r = 0; r < 3; r++) begin
            k = 24'($urandom);
            init_s(); model(k);
            run(k, -1, lat, nw, wb);
            tests++; if (lat != 1537) begin failed++; $display("FAIL rand_latency key=%h: got %0d required 1537", k, lat); end
            tests++; if (nw != 512 || wb != 0) begin failed++; $display("FAIL rand_wren key=%h: count %0d bad %0d, required 512 and 0", k, nw, wb); end
            tests++; if (w_diff() != 0) begin failed++; $display("FAIL rand_write_seq key=%h: %0d writes differ, required 0", k, w_diff()); end
            tests++; if (s_diff() != 0) begin failed++; $display("FAIL rand_final_s key=%h: %0d bytes differ, required 0", k, s_diff()); end
        end
    endtask

    task automatic test_en_ignored();
        int lat, nw, wb;
        logic [23:0] k = 24'($urandom);
        init_s(); model(k);
        run(k, 100, lat, nw, wb);
        tests++; if (lat != 1537) begin failed++; $display("FAIL en_busy_latency: got %0d required 1537", lat); end
        tests++; if (nw != 512) begin failed++; $display("FAIL en_busy_wren_count: got %0d required 512", nw); end
        tests++; if (s_diff() != 0) begin failed++; $display("FAIL en_busy_final_s: %0d bytes differ, required 0", s_diff()); end
    endtask

    task automatic test_reset_mid();
        int lat, nw, wb;
        logic [23:0] k = 24'($urandom);
        init_s();
        @(negedge clk); key = k; en = 1'b1;
        @(negedge clk); en = 1'b0;
        repeat (700) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        tests++;
        if (rdy !== 1'b1 || s_wren !== 1'b0) begin
            failed++;
            $display("FAIL mid_reset: rdy=%b s_wren=%b, required rdy=1 s_wren=0", rdy, s_wren);
        end
        rst = 1'b0;
        k = 24'($urandom);
        init_s(); model(k);
        run(k, -1, lat, nw, wb);
        tests++; if (lat != 1537) begin failed++; $display("FAIL rerun_latency: got %0d required 1537", lat); end
        tests++; if (s_diff() != 0) begin failed++; $display("FAIL rerun_final_s: %0d bytes differ, required 0", s_diff()); end
    endtask

    initial begin
        test_reset();
        test_first_iter();
        test_zero_key();
        test_random_keys();
        test_en_ignored();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
